// File: rtl/agc_monitor_injector.sv
// agc_monitor_injector
//
// Test-set stage that drives the AGC monitor inputs. Words arrive on a
// valid/ready interface and queue in a small FIFO. Each word is presented on
// MDT with MON_n low. After a setup delay the block waits for the AGC
// end-of-memory-cycle pulse (t12) and then issues an MSTRTP strobe. The word
// stays on the bus for a hold period and is then removed. One MON_n-high gap
// cycle always separates consecutive words. While MSTP is high, the block
// stalls before strobing.
//
// Optional build macro:
//   AGC_MON_PARITY_EN  - when defined, MONPAR carries odd parity of MDT.
//                        When undefined, MONPAR is tied low.
//
// Ports:
//   CLOCK       system clock (rising edge)
//   SIM_RST_n   asynchronous active-low reset
//   in_valid    word offered
//   in_ready    FIFO can accept a word
//   in_data     word to send (bit 0 -> MDT01, bit 15 -> MDT16)
//   t12         one-cycle end-of-memory-cycle pulse from the AGC
//   mstp_req    level request to hold the AGC stopped
//   flush       synchronous FIFO clear; aborts a word not yet strobed
//   MDT         monitor data bus
//   MONPAR      monitor parity
//   MSTRTP      monitor start strobe
//   MSTP        mstp_req delayed by one cycle
//   MON_n       low while a word is presented
//   busy        sequencer is not idle
//   fifo_count  FIFO occupancy
//   words_sent  count of completed strobes (wraps)
module agc_monitor_injector #(
  parameter int DEPTH      = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 2
) (
  input  logic                     CLOCK,
  input  logic                     SIM_RST_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_data,
  input  logic                     t12,
  input  logic                     mstp_req,
  input  logic                     flush,
  output logic [15:0]              MDT,
  output logic                     MONPAR,
  output logic                     MSTRTP,
  output logic                     MSTP,
  output logic                     MON_n,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              words_sent
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ARM    = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_t;

`ifdef AGC_MON_PARITY_EN
  // Odd parity: the 16 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity(input logic [15:0] w);
    return ~^w;
  endfunction
`endif

  // FIFO storage and pointers
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      head;
  logic             push, pop;

  assign in_ready = (fifo_count < (PTR_W+1)'(DEPTH));
  // A flush discards any word offered in the same cycle.
  assign push     = in_valid && in_ready && !flush;
  assign head     = mem[rd_ptr];

  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sequencer state and registered monitor outputs
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      mdt_nxt, ws_nxt;
  logic             monpar_nxt, mstrtp_nxt, mon_n_nxt;

  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      state      <= IDLE;
      cnt        <= '0;
      MDT        <= '0;
      MONPAR     <= 1'b0;
      MSTRTP     <= 1'b0;
      MSTP       <= 1'b0;
      MON_n      <= 1'b1;
      words_sent <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      MDT        <= mdt_nxt;
      MONPAR     <= monpar_nxt;
      MSTRTP     <= mstrtp_nxt;
      MSTP       <= mstp_req;
      MON_n      <= mon_n_nxt;
      words_sent <= ws_nxt;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mdt_nxt    = MDT;
    monpar_nxt = MONPAR;
    mstrtp_nxt = MSTRTP;
    mon_n_nxt  = MON_n;
    ws_nxt     = words_sent;
    pop        = 1'b0;

    unique case (state)
      IDLE: begin
        if ((fifo_count != '0) && !flush) begin
          pop        = 1'b1;
          mdt_nxt    = head;
`ifdef AGC_MON_PARITY_EN
          monpar_nxt = odd_parity(head);
`else
          monpar_nxt = 1'b0;
`endif
          mon_n_nxt  = 1'b0;
          cnt_nxt    = CNT_W'(SETUP_CYC);
          state_nxt  = SETUP;
        end
      end

      SETUP: begin
        if (flush) begin
          // Abort before the strobe: the word is withdrawn and not counted.
          mdt_nxt    = '0;
          monpar_nxt = 1'b0;
          mon_n_nxt  = 1'b1;
          state_nxt  = GAP;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt  = ARM;
        end else begin
          cnt_nxt    = cnt - CNT_W'(1);
        end
      end

      ARM: begin
        if (flush) begin
          mdt_nxt    = '0;
          monpar_nxt = 1'b0;
          mon_n_nxt  = 1'b1;
          state_nxt  = GAP;
        end else if (t12 && !MSTP) begin
          mstrtp_nxt = 1'b1;
          cnt_nxt    = CNT_W'(STROBE_CYC);
          state_nxt  = STROBE;
        end
      end

      STROBE: begin
        if (cnt == CNT_W'(1)) begin
          mstrtp_nxt = 1'b0;
          ws_nxt     = words_sent + 16'd1;
          cnt_nxt    = CNT_W'(HOLD_CYC);
          state_nxt  = HOLD;
        end else begin
          cnt_nxt    = cnt - CNT_W'(1);
        end
      end

      HOLD: begin
        if (cnt == CNT_W'(1)) begin
          mdt_nxt    = '0;
          monpar_nxt = 1'b0;
          mon_n_nxt  = 1'b1;
          state_nxt  = GAP;
        end else begin
          cnt_nxt    = cnt - CNT_W'(1);
        end
      end

      GAP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_agc_monitor_injector.sv
module tb_agc_monitor_injector;

  logic        CLOCK;
  logic        SIM_RST_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        t12;
  logic        mstp_req;
  logic        flush;
  logic [15:0] MDT;
  logic        MONPAR;
  logic        MSTRTP;
  logic        MSTP;
  logic        MON_n;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [15:0] words_sent;

  agc_monitor_injector dut (
    .CLOCK      (CLOCK),
    .SIM_RST_n  (SIM_RST_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .t12        (t12),
    .mstp_req   (mstp_req),
    .flush      (flush),
    .MDT        (MDT),
    .MONPAR     (MONPAR),
    .MSTRTP     (MSTRTP),
    .MSTP       (MSTP),
    .MON_n      (MON_n),
    .busy       (busy),
    .fifo_count (fifo_count),
    .words_sent (words_sent)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

`ifdef AGC_MON_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        monpar;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        exp_par;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  int   nvec;
  int   nerr;
  int   strobe_rises;
  int   monn_rises;
  logic prev_strb;
  logic prev_monn;

  function automatic logic exp_par(input logic [15:0] w);
    return PAR_ON ? ~^w : 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock edge, then check any new strobe against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge CLOCK);
    #1;
    if (MSTRTP && !prev_strb) begin
      strobe_rises++;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_mdt", 32'(MDT), 32'(e.data));
        check("sb_monpar", 32'(MONPAR), 32'(e.monpar));
      end
    end
    if (MON_n && !prev_monn) monn_rises++;
    prev_strb = MSTRTP;
    prev_monn = MON_n;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_strobe(input int budget);
    int n;
    n = 0;
    while (!MSTRTP && n < budget) begin
      tick();
      n++;
    end
    check("strobe_timeout", 32'(MSTRTP), 32'd1);
  endtask

  initial begin
    logic [15:0] base;
    logic        rdy;
    int          accepted;

    nvec = 0; nerr = 0; strobe_rises = 0; monn_rises = 0;
    prev_strb = 1'b0; prev_monn = 1'b1;
    SIM_RST_n = 1'b0; in_valid = 1'b0; in_data = '0;
    t12 = 1'b0; mstp_req = 1'b0; flush = 1'b0;

    vecs[0] = '{16'h0000, PAR_ON ? 1'b1 : 1'b0};
    vecs[1] = '{16'h0001, 1'b0};
    vecs[2] = '{16'hFFFF, PAR_ON ? 1'b1 : 1'b0};
    vecs[3] = '{16'h7FFF, 1'b0};
    vecs[4] = '{16'h1234, 1'b0};
    vecs[5] = '{16'hA5A5, PAR_ON ? 1'b1 : 1'b0};

    // Reset state
    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_mdt", 32'(MDT), 32'd0);
    check("rst_monpar", 32'(MONPAR), 32'd0);
    check("rst_mstrtp", 32'(MSTRTP), 32'd0);
    check("rst_mstp", 32'(MSTP), 32'd0);
    check("rst_mon_n", 32'(MON_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_sent), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    SIM_RST_n = 1'b1;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // Basic single word with exact latency
    in_valid = 1'b1; in_data = 16'o000001;
    sb.push_back('{16'h0001, exp_par(16'h0001)});
    tick();                                   // edge N: push
    in_valid = 1'b0;
    check("basic_count1", 32'(fifo_count), 32'd1);
    check("basic_mdt_early", 32'(MDT), 32'd0);
    tick();                                   // N+1: presented
    check("basic_mdt", 32'(MDT), 32'h0001);
    check("basic_mon_n_low", 32'(MON_n), 32'd0);
    check("basic_busy", 32'(busy), 32'd1);
    tick();                                   // N+2
    t12 = 1'b1;
    tick();                                   // N+3: still SETUP, t12 ignored
    check("basic_t12_in_setup", 32'(MSTRTP), 32'd0);
    tick();                                   // N+4: ARM sees t12
    t12 = 1'b0;
    check("basic_strobe", 32'(MSTRTP), 32'd1);
    check("basic_words0", 32'(words_sent), 32'd0);
    tick();                                   // N+5
    check("basic_strobe_end", 32'(MSTRTP), 32'd0);
    check("basic_words1", 32'(words_sent), 32'd1);
    check("basic_hold1", 32'(MDT), 32'h0001);
    tick();                                   // N+6
    check("basic_hold2", 32'(MDT), 32'h0001);
    tick();                                   // N+7: GAP
    check("basic_mdt_clr", 32'(MDT), 32'd0);
    check("basic_mon_n_high", 32'(MON_n), 32'd1);
    check("basic_gap_busy", 32'(busy), 32'd1);
    tick();                                   // N+8: IDLE
    check("basic_idle", 32'(busy), 32'd0);

    // Table-driven words, parity included
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{vecs[i].data, vecs[i].exp_par});
      in_valid = 1'b1; in_data = vecs[i].data;
      tick();
      in_valid = 1'b0;
      tick();
      check("vec_mdt", 32'(MDT), 32'(vecs[i].data));
      check("vec_monpar", 32'(MONPAR), 32'(vecs[i].exp_par));
      check("vec_mon_n", 32'(MON_n), 32'd0);
      t12 = 1'b1;
      wait_strobe(20);
      t12 = 1'b0;
      wait_idle(20);
      check("vec_mdt_clr", 32'(MDT), 32'd0);
      check("vec_monpar_clr", 32'(MONPAR), 32'd0);
    end
    check("vec_words", 32'(words_sent), 32'd7);

    // Full FIFO: 5 accepted (1 held + 4 queued), 6th refused
    base = words_sent;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = 16'h0100 + 16'(k);
      rdy = in_ready;
      tick();
      if (rdy) begin
        accepted++;
        sb.push_back('{16'h0100 + 16'(k), exp_par(16'h0100 + 16'(k))});
      end
      if (k == 4) check("full_ready_drop", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("full_accepted", 32'(accepted), 32'd5);
    check("full_count", 32'(fifo_count), 32'd4);
    strobe_rises = 0; monn_rises = 0;
    t12 = 1'b1;
    for (int n = 0; n < 200 && words_sent != base + 16'd5; n++) tick();
    t12 = 1'b0;
    wait_idle(20);
    check("full_words", 32'(words_sent), 32'(base + 16'd5));
    check("full_strobes", 32'(strobe_rises), 32'd5);
    check("full_mon_n_gaps", 32'(monn_rises), 32'd5);

    // MSTP stall in ARM
    mstp_req = 1'b1;
    tick();
    check("stall_mstp_on", 32'(MSTP), 32'd1);
    sb.push_back('{16'h5555, exp_par(16'h5555)});
    in_valid = 1'b1; in_data = 16'h5555;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    strobe_rises = 0;
    for (int k = 0; k < 3; k++) begin
      t12 = 1'b1; tick();
      t12 = 1'b0; tick();
    end
    check("stall_no_strobe", 32'(strobe_rises), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    mstp_req = 1'b0;
    tick();
    check("stall_mstp_off", 32'(MSTP), 32'd0);
    t12 = 1'b1; tick(); t12 = 1'b0;
    check("stall_strobe", 32'(MSTRTP), 32'd1);
    tick();
    check("stall_strobe_end", 32'(MSTRTP), 32'd0);
    wait_idle(20);
    check("stall_one_strobe", 32'(strobe_rises), 32'd1);

    // Flush during SETUP, with a discarded same-cycle push
    base = words_sent;
    strobe_rises = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 16'h0A00 + 16'(k);
      tick();
    end
    in_data = 16'hDEAD; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_mdt", 32'(MDT), 32'd0);
    check("flush_mon_n", 32'(MON_n), 32'd1);
    check("flush_gap_busy", 32'(busy), 32'd1);
    tick();
    check("flush_idle", 32'(busy), 32'd0);
    t12 = 1'b1;
    repeat (4) tick();
    t12 = 1'b0;
    check("flush_stays_idle", 32'(busy), 32'd0);
    check("flush_words", 32'(words_sent), 32'(base));
    check("flush_no_strobe", 32'(strobe_rises), 32'd0);

    // Asynchronous reset while MSTRTP is high
    sb.push_back('{16'h0F0F, exp_par(16'h0F0F)});
    in_valid = 1'b1; in_data = 16'h0F0F;
    tick();
    in_data = 16'h00FF;
    tick();
    in_valid = 1'b0;
    t12 = 1'b1;
    wait_strobe(20);
    t12 = 1'b0;
    check("arst_pre_count", 32'(fifo_count), 32'd1);
    #2;
    SIM_RST_n = 1'b0;
    #1;
    check("arst_mstrtp", 32'(MSTRTP), 32'd0);
    check("arst_mdt", 32'(MDT), 32'd0);
    check("arst_monpar", 32'(MONPAR), 32'd0);
    check("arst_mon_n", 32'(MON_n), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_words", 32'(words_sent), 32'd0);
    check("arst_mstp", 32'(MSTP), 32'd0);
    #1;
    SIM_RST_n = 1'b1;
    tick();
    check("arst_after_idle", 32'(busy), 32'd0);
    check("arst_after_ready", 32'(in_ready), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
